// File: rtl/sdram_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdram_responder_if : SDR SDRAM command/control bus (DQ travels separately)
// Revision 1.0
// ----------------------------------------------------------------------------
interface sdram_responder_if;
    logic        cke;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [1:0]  dmask;
    logic        err;

    modport master (output cke, cs_n, ras_n, cas_n, we_n, ba, addr, dmask, input err);
    modport slave  (input  cke, cs_n, ras_n, cas_n, we_n, ba, addr, dmask, output err);
endinterface
`default_nettype wire

// File: rtl/sdram_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdram_responder : SDR SDRAM device model with on-chip storage array
// Revision 1.0
// ----------------------------------------------------------------------------
module sdram_responder #(
    parameter int ROW_BITS = 2,
    parameter int COL_BITS = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    sdram_responder_if.slave bus,
    inout  wire [15:0]       dq
);
    localparam int IW    = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << IW;
    localparam int QD    = 5;

    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;
    localparam logic [3:0] C_BST = 4'b0110;

    logic [15:0]         mem [DEPTH];
    logic [3:0]          r_active;
    logic [ROW_BITS-1:0] r_row [4];
    logic                r_cl3;
    logic [1:0]          r_bl_mask;
    logic                r_err;
    logic                r_oe;
    logic [15:0]         r_dq;

    // Read schedule: slot p holds the beat driven at the (p+1)-th edge from now.
    logic [QD-1:0]       r_qv, r_qa;
    logic [IW-1:0]       r_qi [QD];

    logic                r_wr_busy, r_wr_ap;
    logic [1:0]          r_wr_bank, r_wr_k, r_wr_mask;
    logic [ROW_BITS-1:0] r_wr_row;
    logic [COL_BITS-1:0] r_wr_col;

    logic [3:0]          w_cmd;
    logic                w_act, w_rd, w_wr, w_pre, w_ref, w_mrs, w_bst;
    logic                w_bank_act, w_any_act, w_rd_ok, w_wr_ok, w_act_ok;
    logic                w_mrs_legal, w_mrs_ok, w_err_set, w_rw_cancel;
    logic [2:0]          w_cl_off;
    logic [COL_BITS-1:0] w_col;
    logic [QD-1:0]       w_qv_n, w_qa_n;
    logic [IW-1:0]       w_qi_n [QD];
    logic [3:0]          w_close, w_open;
    logic                w_wr_kill, w_wr_cont, w_wr_beat;
    logic [IW-1:0]       w_wr_idx;
    logic                w_unused;

    function automatic logic [COL_BITS-1:0] beat_col(input logic [COL_BITS-1:0] col,
                                                      input logic [1:0] mask,
                                                      input logic [1:0] k);
        logic [COL_BITS-1:0] m;
        m = {{(COL_BITS-2){1'b0}}, mask};
        return (col & ~m) | ((col + {{(COL_BITS-2){1'b0}}, k}) & m);
    endfunction

    assign w_cmd       = {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n};
    assign w_act       = bus.cke && (w_cmd == C_ACT);
    assign w_rd        = bus.cke && (w_cmd == C_RD);
    assign w_wr        = bus.cke && (w_cmd == C_WR);
    assign w_pre       = bus.cke && (w_cmd == C_PRE);
    assign w_ref       = bus.cke && (w_cmd == C_REF);
    assign w_mrs       = bus.cke && (w_cmd == C_MRS);
    assign w_bst       = bus.cke && (w_cmd == C_BST);
    assign w_bank_act  = r_active[bus.ba];
    assign w_any_act   = |r_active;
    assign w_rd_ok     = w_rd && w_bank_act;
    assign w_wr_ok     = w_wr && w_bank_act;
    assign w_act_ok    = w_act && !w_bank_act;
    assign w_mrs_legal = ((bus.addr[6:4] == 3'd2) || (bus.addr[6:4] == 3'd3)) && (bus.addr[2:0] <= 3'd2);
    assign w_mrs_ok    = w_mrs && !w_any_act && w_mrs_legal;
    assign w_err_set   = (w_act && w_bank_act) || ((w_rd || w_wr) && !w_bank_act) ||
                         (w_ref && w_any_act) || (w_mrs && (w_any_act || !w_mrs_legal));
    assign w_rw_cancel = w_bst || w_rd_ok || w_wr_ok;
    assign w_cl_off    = r_cl3 ? 3'd1 : 3'd0;
    assign w_col       = bus.addr[COL_BITS-1:0];
    assign w_unused    = &{1'b0, bus.addr};

    assign w_wr_kill = r_wr_busy && (w_rw_cancel || (w_pre && (bus.addr[10] || (bus.ba == r_wr_bank))));
    assign w_wr_cont = bus.cke && r_wr_busy && !w_wr_kill;
    assign w_wr_beat = w_wr_ok || w_wr_cont;
    assign w_wr_idx  = w_wr_ok ? {bus.ba, r_row[bus.ba], w_col}
                               : {r_wr_bank, r_wr_row, beat_col(r_wr_col, r_wr_mask, r_wr_k)};

    always_comb begin
        w_open  = '0;
        w_close = '0;
        if (w_act_ok) w_open[bus.ba] = 1'b1;
        if (w_pre) begin
            if (bus.addr[10]) w_close = 4'hF;
            else              w_close[bus.ba] = 1'b1;
        end
        if (bus.cke && r_qv[0] && r_qa[0]) w_close[r_qi[0][IW-1 -: 2]] = 1'b1;
        if (w_wr_kill && r_wr_ap) w_close[r_wr_bank] = 1'b1;
        if (w_wr_cont && r_wr_ap && (r_wr_k == r_wr_mask)) w_close[r_wr_bank] = 1'b1;
        if (w_wr_ok && bus.addr[10] && (r_bl_mask == 2'd0)) w_close[bus.ba] = 1'b1;

        for (int p = 0; p < QD - 1; p++) begin
            w_qv_n[p] = r_qv[p+1];
            w_qa_n[p] = r_qa[p+1];
            w_qi_n[p] = r_qi[p+1];
        end
        w_qv_n[QD-1] = 1'b0;
        w_qa_n[QD-1] = 1'b0;
        w_qi_n[QD-1] = '0;

        // Beats that would start at or after M+CL-1 are dropped; earlier ones drain.
        for (int p = 0; p < QD; p++) begin
            if (w_qv_n[p] && (3'(p) >= w_cl_off) &&
                (w_rw_cancel || (w_pre && (bus.addr[10] || (w_qi_n[p][IW-1 -: 2] == bus.ba))))) begin
                w_qv_n[p] = 1'b0;
                if (w_qa_n[p]) w_close[w_qi_n[p][IW-1 -: 2]] = 1'b1;
            end
        end

        for (int p = 0; p < QD; p++) begin
            if (w_rd_ok && (3'(p) >= w_cl_off) && ((3'(p) - w_cl_off) <= {1'b0, r_bl_mask})) begin
                w_qv_n[p] = 1'b1;
                w_qi_n[p] = {bus.ba, r_row[bus.ba], beat_col(w_col, r_bl_mask, 2'(3'(p) - w_cl_off))};
                w_qa_n[p] = bus.addr[10] && ((3'(p) - w_cl_off) == {1'b0, r_bl_mask});
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= '0;
            r_cl3     <= 1'b0;
            r_bl_mask <= 2'd1;
            r_err     <= 1'b0;
            r_oe      <= 1'b0;
            r_qv      <= '0;
            r_qa      <= '0;
            for (int b = 0; b < 4; b++) r_row[b] <= '0;
            for (int p = 0; p < QD; p++) r_qi[p] <= '0;
            r_wr_busy <= 1'b0;
            r_wr_ap   <= 1'b0;
            r_wr_bank <= '0;
            r_wr_k    <= '0;
            r_wr_mask <= '0;
            r_wr_row  <= '0;
            r_wr_col  <= '0;
        end else if (bus.cke) begin
            r_oe     <= r_qv[0];
            r_qv     <= w_qv_n;
            r_qa     <= w_qa_n;
            for (int p = 0; p < QD; p++) r_qi[p] <= w_qi_n[p];
            r_active <= (r_active & ~w_close) | w_open;
            if (w_act_ok)  r_row[bus.ba] <= bus.addr[ROW_BITS-1:0];
            if (w_err_set) r_err <= 1'b1;
            if (w_mrs_ok) begin
                r_cl3 <= (bus.addr[6:4] == 3'd3);
                case (bus.addr[2:0])
                    3'd0:    r_bl_mask <= 2'd0;
                    3'd1:    r_bl_mask <= 2'd1;
                    default: r_bl_mask <= 2'd3;
                endcase
            end
            if (w_wr_ok) begin
                r_wr_busy <= (r_bl_mask != 2'd0);
                r_wr_ap   <= bus.addr[10];
                r_wr_bank <= bus.ba;
                r_wr_row  <= r_row[bus.ba];
                r_wr_col  <= w_col;
                r_wr_k    <= 2'd1;
                r_wr_mask <= r_bl_mask;
            end else if (r_wr_busy) begin
                if (w_wr_kill || (r_wr_k == r_wr_mask)) r_wr_busy <= 1'b0;
                else                                     r_wr_k    <= r_wr_k + 2'd1;
            end
        end
    end

    // Read captures the pre-write word when both hit the same address on one edge.
    always_ff @(posedge clk) begin
        if (bus.cke) begin
            if (r_qv[0]) r_dq <= mem[r_qi[0]];
            if (w_wr_beat) begin
                if (!bus.dmask[1]) mem[w_wr_idx][15:8] <= dq[15:8];
                if (!bus.dmask[0]) mem[w_wr_idx][7:0]  <= dq[7:0];
            end
        end
    end

    assign dq      = r_oe ? r_dq : 16'hzzzz;
    assign bus.err = r_err;
endmodule
`default_nettype wire

// File: tb/tb_sdram_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sdram_responder : directed scoreboard bench for sdram_responder
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_sdram_responder;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_MRS = 4'b0000;
    localparam logic [3:0] C_BST = 4'b0110;
    localparam logic [15:0] C_HIZ = 16'hFFFF;

    typedef struct packed {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        tb_dq_en;
    logic [15:0] tb_dq;
    wire  [15:0] dq;
    int          edge_n;
    int          tb_cl;
    int          n_cmp;
    int          n_bad;
    exp_t        sb[$];

    sdram_responder_if bus();

    sdram_responder #(.ROW_BITS(2), .COL_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .dq    (dq)
    );

    assign dq = tb_dq_en ? tb_dq : 16'hzzzz;
    pullup (dq);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, want, edge_n);
        end
    endtask

    task automatic check_dq();
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc == edge_n) begin
            e = sb.pop_front();
            check("dq_beat", dq, e.data);
        end else begin
            check("dq_hiz", dq, C_HIZ);
        end
    endtask

    task automatic idle();
        {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} = C_NOP;
        bus.ba    = 2'd0;
        bus.addr  = 13'd0;
        bus.dmask = 2'b11;
        tb_dq_en  = 1'b0;
        tb_dq     = 16'h0000;
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr,
                         input logic den, input logic [15:0] dv, input logic [1:0] dm);
        {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} = c;
        bus.ba    = ba;
        bus.addr  = addr;
        bus.dmask = dm;
        tb_dq_en  = den;
        tb_dq     = dv;
        @(posedge clk);
        edge_n++;
        #1;
        idle();
        @(negedge clk);
        check_dq();
    endtask

    // Expected read beats that start at or after M+CL-1 are withdrawn.
    task automatic cancel_reads();
        exp_t keep[$];
        int   lim;
        lim = edge_n + tb_cl;
        foreach (sb[i]) if (sb[i].cyc < lim) keep.push_back(sb[i]);
        sb = keep;
    endtask

    task automatic cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr);
        if (c == C_BST || c == C_PRE) cancel_reads();
        drive(c, ba, addr, 1'b0, 16'h0000, 2'b11);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) drive(C_NOP, 2'd0, 13'd0, 1'b0, 16'h0000, 2'b11);
    endtask

    task automatic wr(input logic [1:0] ba, input logic [12:0] addr, input int nb,
                      input logic [63:0] d, input logic [7:0] m);
        cancel_reads();
        drive(C_WR, ba, addr, 1'b1, d[15:0], m[1:0]);
        for (int k = 1; k < nb; k++) drive(C_NOP, 2'd0, 13'd0, 1'b1, d[16*k +: 16], m[2*k +: 2]);
    endtask

    task automatic rd(input logic [1:0] ba, input logic [12:0] addr, input int nb, input logic [63:0] d);
        exp_t e;
        cancel_reads();
        for (int k = 0; k < nb; k++) begin
            e.cyc  = edge_n + tb_cl + k;
            e.data = d[16*k +: 16];
            sb.push_back(e);
        end
        drive(C_RD, ba, addr, 1'b0, 16'h0000, 2'b11);
    endtask

    task automatic check_err(input string tag, input logic want);
        check(tag, {15'd0, bus.err}, {15'd0, want});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_dq_hiz", dq, C_HIZ);
        check_err("rst_err", 1'b0);
        sb.delete();
        tb_cl = 2;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        edge_n = 0;
        tb_cl  = 2;
        rst_n  = 1'b0;
        bus.cke = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        check("init_dq_hiz", dq, C_HIZ);
        check_err("init_err", 1'b0);
        rst_n = 1'b1;

        // Basic write/read, CL=2 BL=2
        cmd(C_MRS, 2'd0, 13'h021);
        cmd(C_ACT, 2'd1, 13'd5);
        wr(2'd1, 13'h010, 2, {32'h0, 16'h1234, 16'hBEEF}, 8'h00);
        nops(1);
        rd(2'd1, 13'h010, 2, {32'h0, 16'h1234, 16'hBEEF});
        nops(3);

        // Byte masks
        wr(2'd1, 13'h020, 2, {32'h0, 16'h1111, 16'h1111}, 8'h00);
        wr(2'd1, 13'h020, 2, {32'h0, 16'h0000, 16'hAA55}, 8'b0000_1101);
        rd(2'd1, 13'h020, 2, {32'h0, 16'h1111, 16'hAA11});
        nops(3);
        wr(2'd1, 13'h020, 2, {32'h0, 16'h1111, 16'h1111}, 8'h00);
        wr(2'd1, 13'h020, 2, {32'h0, 16'h0000, 16'hAA55}, 8'b0000_1110);
        rd(2'd1, 13'h020, 2, {32'h0, 16'h1111, 16'h1155});
        nops(3);

        // Burst terminate on a write
        wr(2'd1, 13'h030, 2, {32'h0, 16'h3131, 16'h3030}, 8'h00);
        drive(C_WR, 2'd1, 13'h030, 1'b1, 16'h5A5A, 2'b00);
        cancel_reads();
        drive(C_BST, 2'd1, 13'h000, 1'b1, 16'hFFFF, 2'b00);
        rd(2'd1, 13'h030, 2, {32'h0, 16'h3131, 16'h5A5A});
        nops(3);

        // Burst terminate on a CL=3 read
        cmd(C_PRE, 2'd0, 13'h400);
        cmd(C_MRS, 2'd0, 13'h031);
        tb_cl = 3;
        cmd(C_ACT, 2'd1, 13'd5);
        rd(2'd1, 13'h030, 2, {32'h0, 16'h3131, 16'h5A5A});
        cmd(C_BST, 2'd1, 13'h000);
        nops(4);
        check_err("err_clean", 1'b0);

        // BL=4 wrap, auto-precharge, read to idle bank
        cmd(C_PRE, 2'd0, 13'h400);
        cmd(C_MRS, 2'd0, 13'h022);
        tb_cl = 2;
        cmd(C_ACT, 2'd1, 13'd5);
        wr(2'd1, 13'h00D, 4, {16'h0C0C, 16'h0F0F, 16'h0E0E, 16'h0D0D}, 8'h00);
        rd(2'd1, 13'h00E, 4, {16'h0D0D, 16'h0C0C, 16'h0F0F, 16'h0E0E});
        nops(5);
        rd(2'd1, 13'h40C, 4, {16'h0F0F, 16'h0E0E, 16'h0D0D, 16'h0C0C});
        nops(5);
        check_err("err_before_idle_rd", 1'b0);
        cmd(C_RD, 2'd1, 13'h00C);
        nops(3);
        check_err("err_idle_rd", 1'b1);
        do_reset();

        // MRS while a bank is open; CL stays 2
        cmd(C_ACT, 2'd0, 13'd0);
        cmd(C_MRS, 2'd0, 13'h031);
        check_err("err_mrs_open", 1'b1);
        cmd(C_PRE, 2'd0, 13'h400);
        cmd(C_ACT, 2'd1, 13'd5);
        rd(2'd1, 13'h010, 2, {32'h0, 16'h1234, 16'hBEEF});
        nops(3);
        do_reset();

        // Illegal CAS latency
        cmd(C_MRS, 2'd0, 13'h051);
        check_err("err_mrs_cl5", 1'b1);
        cmd(C_ACT, 2'd1, 13'd5);
        rd(2'd1, 13'h010, 2, {32'h0, 16'h1234, 16'hBEEF});
        nops(3);
        do_reset();

        // Double ACT, then reset in the middle of a read burst
        cmd(C_ACT, 2'd2, 13'd0);
        check_err("err_act_once", 1'b0);
        cmd(C_ACT, 2'd2, 13'd1);
        check_err("err_act_twice", 1'b1);
        cmd(C_ACT, 2'd1, 13'd5);
        rd(2'd1, 13'h010, 2, {32'h0, 16'h1234, 16'hBEEF});
        nops(1);
        do_reset();
        cmd(C_RD, 2'd1, 13'h010);
        nops(3);
        check_err("err_rd_after_reset", 1'b1);
        check("sb_drained", 16'(sb.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
